mobile_transmitter: RTL and testbench
=====================================

# mobile_transmitter

Outbound counterpart to the phone receiver: buffers bytes written by the CPU datapath and presents them to the phone's 8-bit parallel input port under a four-phase strobe/acknowledge handshake. It sits beside the receiver in the top level. The FSM drives `wr_en`, the low byte of the register bus drives `wr_data`, and `tx_*` go to GPIO pins. It also reports overflow and handshake-timeout errors to the CPU.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SETTLE`, 4: cycles `tx_data` is stable before `tx_strobe` rises; ≥1.
- `TIMEOUT`, 50_000_000: maximum cycles to wait in either handshake phase; ≥2.

- `clk`  in  1  single system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  single-cycle write pulse from the FSM.
- `wr_data`  in  8  byte to send; sampled when `wr_en` is high.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `tx_data`  out  8  byte presented to the phone.
- `tx_strobe`  out  1  data-valid strobe to the phone.
- `tx_ack`  in  1  acknowledge from the phone; asynchronous to `clk`.
- `overflow`  out  1  sticky: a write arrived while full.
- `timeout_err`  out  1  sticky: a handshake phase timed out.
- `clr_err`  in  1  clears both sticky flags.

## Operation
- FIFO is DEPTH×8 with `log2(DEPTH)+1`-bit read/write pointers.
  - `full`/`empty` are derived from registered pointers only.
- A write when `full` is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- A write when not full is accepted. Simultaneous push and pop are both allowed.
- `tx_ack` passes through a 2-FF synchronizer, giving `ack_s`. Only `ack_s` is used internally.
- FSM states and transitions:
  - IDLE: `tx_strobe`=0. If `!empty`, load the head byte into `tx_data`, clear the counter, go to SETUP.
  - SETUP: hold `tx_data`; count to SETTLE, then go to STROBE.
  - STROBE: `tx_strobe`=1. When `ack_s`=1: pop the FIFO, go to RELEASE.
    - On timeout: pop the FIFO (byte discarded), set `timeout_err`, go to RELEASE.
  - RELEASE: `tx_strobe`=0, `tx_data` held. When `ack_s`=0, go to IDLE.
    - On timeout: set `timeout_err`, go to IDLE.
- The timeout counter is cleared on every state entry and saturates. Timeout fires when the count reaches TIMEOUT−1.
- Setting a sticky flag wins over `clr_err` in the same cycle.
- Reset mid-transfer (`rst` low in any state) is asynchronous:
  - state goes to IDLE, pointers to 0, FIFO contents are lost;
  - `tx_strobe` goes low immediately.

## Timing
- Reset values:
  - `tx_data`=0x00, `tx_strobe`=0, `full`=0, `empty`=1;
  - `overflow`=0, `timeout_err`=0; FSM in IDLE; synchronizer flops 0.
- `wr_en` at edge N into an empty FIFO:
  - `empty` falls after edge N;
  - `tx_data` is valid after edge N+1;
  - `tx_strobe` rises after edge N+1+SETTLE.
- Acknowledge path: `tx_ack` rising is seen as `ack_s` two edges later. The pop and `tx_strobe` fall happen on the following edge.
- Falling `ack_s` returns the FSM to IDLE on the next edge. A queued byte then reaches `tx_data` one edge after that.
- Minimum cycles per byte with an instant phone: 1 + SETTLE + 3 + 3.
- `tx_data` changes only on the IDLE→SETUP transition, so it is glitch-free while `tx_strobe` is high.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, SETUP, STROBE, RELEASE);
  - the default SETTLE/TIMEOUT constants, so the receiver and the top level use the same values.
- One sub-module is natural: `sync_fifo`, a parameterized width/depth FIFO with registered `full`/`empty`, reusable by the VGA path.
- The 2-FF synchronizer stays inline.

## Test plan
- Reset, then write 0xA5; the phone model acks 5 cycles after strobe and releases 5 cycles later:
  - `tx_data`=0xA5 after edge 1;
  - strobe high after edge 5;
  - `empty`=1 after the pop.
- Write 0x01, 0x02, 0x03, 0x04, 0x05 back-to-back with DEPTH=4 and the phone stalled:
  - `full` after the 4th write;
  - `overflow`=1 after the 5th;
  - bytes then arrive in order 01..04 and 0x05 never appears.
- Phone never acks, TIMEOUT=16:
  - strobe stays high 16 cycles, then falls;
  - `timeout_err`=1; byte popped; next byte proceeds.
- Phone holds ack high forever after one byte:
  - RELEASE times out, `timeout_err`=1, FSM returns to IDLE;
  - `clr_err` then clears the flag.
- Assert `rst` low while in STROBE with 3 bytes queued:
  - `tx_strobe`=0 and `empty`=1 immediately, with no clock edge needed;
  - after release, no transfer starts until a new write.
- Write and ack-pop in the same cycle at count 2: count remains 2, and `full`/`empty` stay 0.

Source files
------------

// File: rtl/mobile_transmitter_pkg.sv
// rtl/mobile_transmitter_pkg.sv - shared FSM states and handshake timing defaults
package mobile_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_t;

    localparam int unsigned SETTLE_DEFAULT  = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 50_000_000;

endpackage

// File: rtl/mobile_transmitter_if.sv
// rtl/mobile_transmitter_if.sv - CPU write port, status flags and phone handshake pins
interface mobile_transmitter_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_ack;
    logic       overflow;
    logic       timeout_err;
    logic       clr_err;

    modport master (
        output wr_en, wr_data, tx_ack, clr_err,
        input  full, empty, tx_data, tx_strobe, overflow, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, tx_ack, clr_err,
        output full, empty, tx_data, tx_strobe, overflow, timeout_err
    );

endinterface

// File: rtl/mobile_transmitter_sync_fifo.sv
// rtl/mobile_transmitter_sync_fifo.sv - width/depth parameterized FIFO with pointer-derived full/empty
module mobile_transmitter_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mobile_transmitter.sv
// rtl/mobile_transmitter.sv - buffers CPU bytes and sends them to the phone with a strobe/ack handshake
module mobile_transmitter
    import mobile_transmitter_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned SETTLE  = SETTLE_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    mobile_transmitter_if.slave  bus
);

    localparam int unsigned CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    tx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          strobe_q, strobe_d;
    logic [7:0]    data_q;
    logic          ack_meta, ack_s;
    logic          overflow_q, timeout_q;
    logic          load, pop, set_timeout, at_timeout;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;

    mobile_transmitter_sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign at_timeout = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_inc;
        strobe_d    = 1'b0;
        load        = 1'b0;
        pop         = 1'b0;
        set_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    load    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d  = ST_STROBE;
                    cnt_d    = '0;
                    strobe_d = 1'b1;
                end
            end
            ST_STROBE: begin
                strobe_d = 1'b1;
                if (ack_s || at_timeout) begin
                    // A timed-out byte is discarded so one dead phone cannot wedge the queue.
                    pop         = 1'b1;
                    set_timeout = !ack_s;
                    state_d     = ST_RELEASE;
                    cnt_d       = '0;
                    strobe_d    = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!ack_s || at_timeout) begin
                    set_timeout = ack_s;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            strobe_q   <= 1'b0;
            data_q     <= 8'h00;
            ack_meta   <= 1'b0;
            ack_s      <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            ack_meta <= bus.tx_ack;
            ack_s    <= ack_meta;
            if (load) data_q <= fifo_head;
            // Setting a flag takes priority over a simultaneous clear.
            if (bus.wr_en && fifo_full) overflow_q <= 1'b1;
            else if (bus.clr_err)       overflow_q <= 1'b0;
            if (set_timeout)            timeout_q  <= 1'b1;
            else if (bus.clr_err)       timeout_q  <= 1'b0;
        end
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.tx_data     = data_q;
    assign bus.tx_strobe   = strobe_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_mobile_transmitter.sv
// tb/tb_mobile_transmitter.sv - directed vector bench for mobile_transmitter
module tb_mobile_transmitter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mobile_transmitter_if bus();

    mobile_transmitter #(.DEPTH(4), .SETTLE(4), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_ack;
        logic       full;
        logic       empty;
        logic [7:0] tx_data;
        logic       tx_strobe;
        logic       overflow;
        logic       timeout_err;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic [7:0] d, input logic ack,
                           input logic e, input logic [7:0] td, input logic s, input int n);
        vec_t v;
        v.wr_en = wr; v.wr_data = d; v.tx_ack = ack;
        v.full = 1'b0; v.empty = e; v.tx_data = td; v.tx_strobe = s;
        v.overflow = 1'b0; v.timeout_err = 1'b0;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic wait_strobe(input logic lvl, input string name);
        int n;
        n = 0;
        while (bus.tx_strobe !== lvl && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (bus.tx_strobe !== lvl) begin
            errors++;
            $display("FAIL %s: strobe did not reach %b within 64 cycles", name, lvl);
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic phone_xfer(input string name, input int ack_delay, output logic [7:0] b);
        wait_strobe(1'b1, {name, ".rise"});
        b = bus.tx_data;
        repeat (ack_delay) step();
        bus.tx_ack = 1'b1;
        wait_strobe(1'b0, {name, ".fall"});
        repeat (2) step();
        bus.tx_ack = 1'b0;
        repeat (4) step();
    endtask

    task automatic clear_errors();
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic       saw;
        int         n;

        bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.tx_ack = 1'b0; bus.clr_err = 1'b0;

        #2;
        check_bit("rst.strobe", bus.tx_strobe, 1'b0);
        check_bit("rst.empty", bus.empty, 1'b1);
        check_bit("rst.full", bus.full, 1'b0);
        check_byte("rst.data", bus.tx_data, 8'h00);
        check_bit("rst.overflow", bus.overflow, 1'b0);
        check_bit("rst.timeout", bus.timeout_err, 1'b0);
        repeat (2) step();
        rst = 1'b1;

        // Single byte: ack 5 cycles after strobe, release 5 cycles later.
        add_vec(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 4);
        add_vec(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 5);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b1, 2);
        add_vec(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 3);
        add_vec(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 4);
        for (int i = 0; i < vecs.size(); i++) begin
            bus.wr_en = vecs[i].wr_en;
            bus.wr_data = vecs[i].wr_data;
            bus.tx_ack = vecs[i].tx_ack;
            step();
            check_bit($sformatf("vec%0d.full", i), bus.full, vecs[i].full);
            check_bit($sformatf("vec%0d.empty", i), bus.empty, vecs[i].empty);
            check_byte($sformatf("vec%0d.data", i), bus.tx_data, vecs[i].tx_data);
            check_bit($sformatf("vec%0d.strobe", i), bus.tx_strobe, vecs[i].tx_strobe);
            check_bit($sformatf("vec%0d.overflow", i), bus.overflow, vecs[i].overflow);
            check_bit($sformatf("vec%0d.timeout", i), bus.timeout_err, vecs[i].timeout_err);
        end

        // Overflow: five writes into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i));
            if (i == 4) check_bit("ovf.full4", bus.full, 1'b1);
            if (i == 5) begin
                check_bit("ovf.flag", bus.overflow, 1'b1);
                check_bit("ovf.full5", bus.full, 1'b1);
            end
        end
        for (int i = 1; i <= 4; i++) begin
            phone_xfer($sformatf("ovf.x%0d", i), 2, b);
            check_byte($sformatf("ovf.byte%0d", i), b, 8'(i));
        end
        saw = 1'b0;
        repeat (40) begin
            step();
            if (bus.tx_strobe) saw = 1'b1;
        end
        check_bit("ovf.no5th", saw, 1'b0);
        check_bit("ovf.empty", bus.empty, 1'b1);
        clear_errors();
        check_bit("ovf.clr", bus.overflow, 1'b0);

        // Strobe-phase timeout: phone never acks the first byte.
        write_byte(8'h11);
        write_byte(8'h22);
        wait_strobe(1'b1, "to.rise");
        check_byte("to.first", bus.tx_data, 8'h11);
        n = 1;
        step();
        while (bus.tx_strobe && n < 100) begin
            n++;
            step();
        end
        check_int("to.strobe_len", n, 16);
        check_bit("to.flag", bus.timeout_err, 1'b1);
        check_bit("to.popped", bus.empty, 1'b0);
        phone_xfer("to.next", 2, b);
        check_byte("to.next_byte", b, 8'h22);
        check_bit("to.empty", bus.empty, 1'b1);
        clear_errors();
        check_bit("to.clr", bus.timeout_err, 1'b0);

        // Release-phase timeout: ack stays high after the pop.
        write_byte(8'h33);
        wait_strobe(1'b1, "rel.rise");
        bus.tx_ack = 1'b1;
        wait_strobe(1'b0, "rel.fall");
        repeat (15) step();
        check_bit("rel.before", bus.timeout_err, 1'b0);
        step();
        check_bit("rel.flag", bus.timeout_err, 1'b1);
        check_bit("rel.empty", bus.empty, 1'b1);
        clear_errors();
        check_bit("rel.clr", bus.timeout_err, 1'b0);
        bus.tx_ack = 1'b0;
        repeat (3) step();
        write_byte(8'h44);
        phone_xfer("rel.after", 1, b);
        check_byte("rel.after_byte", b, 8'h44);

        // Push and pop in the same cycle with two entries queued.
        write_byte(8'h91);
        write_byte(8'h92);
        wait_strobe(1'b1, "pp.rise");
        check_byte("pp.first", bus.tx_data, 8'h91);
        bus.tx_ack = 1'b1;
        repeat (2) step();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h93;
        step();
        bus.wr_en = 1'b0;
        check_bit("pp.popped", bus.tx_strobe, 1'b0);
        check_bit("pp.full", bus.full, 1'b0);
        check_bit("pp.empty", bus.empty, 1'b0);
        repeat (2) step();
        bus.tx_ack = 1'b0;
        phone_xfer("pp.x2", 2, b);
        check_byte("pp.byte2", b, 8'h92);
        phone_xfer("pp.x3", 2, b);
        check_byte("pp.byte3", b, 8'h93);
        check_bit("pp.drained", bus.empty, 1'b1);

        // Asynchronous reset while strobing with three bytes queued.
        write_byte(8'h55);
        write_byte(8'h66);
        write_byte(8'h77);
        wait_strobe(1'b1, "ar.rise");
        #2;
        rst = 1'b0;
        #1;
        check_bit("ar.strobe", bus.tx_strobe, 1'b0);
        check_bit("ar.empty", bus.empty, 1'b1);
        check_byte("ar.data", bus.tx_data, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            step();
            if (bus.tx_strobe || !bus.empty) saw = 1'b1;
        end
        check_bit("ar.quiet", saw, 1'b0);
        write_byte(8'h88);
        phone_xfer("ar.new", 2, b);
        check_byte("ar.new_byte", b, 8'h88);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
